// File: rtl/mips16_pkg.sv
// ----------------------------------------------------------------------------
// mips16_pkg
// Shared definitions for the MIPS16 decode stage:
//   - opcode / R-type function constants
//   - instruction field bit positions
//   - ctrl vector bit indices and the ctrl_t packed struct
//   - small decode helper functions
// Configuration macro used by users of this package: ID_WB_BYPASS_EN
// (see regfile_p).
// ----------------------------------------------------------------------------
package mips16_pkg;

    // Register-address fields are always 3 bits wide.
    localparam int REG_ADDR_W = 3;
    localparam int MAX_REGS   = 1 << REG_ADDR_W;
    localparam int INST_W     = 16;
    localparam int CTRL_W     = 7;

    // Opcodes (inst[15:13])
    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_ADDI  = 3'd1;
    localparam logic [2:0] OP_ORI   = 3'd2;
    localparam logic [2:0] OP_SLTI  = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;
    localparam logic [2:0] OP_BNE   = 3'd5;
    localparam logic [2:0] OP_LW    = 3'd6;
    localparam logic [2:0] OP_SW    = 3'd7;

    // R-type function codes (inst[3:0])
    localparam logic [3:0] FN_SLL = 4'd0;
    localparam logic [3:0] FN_ADD = 4'd1;
    localparam logic [3:0] FN_SUB = 4'd2;
    localparam logic [3:0] FN_AND = 4'd3;
    localparam logic [3:0] FN_OR  = 4'd4;
    localparam logic [3:0] FN_XOR = 4'd5;
    localparam logic [3:0] FN_SLT = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;

    // Instruction field bit positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RS_HI  = 12;
    localparam int RS_LO  = 10;
    localparam int RT_HI  = 9;
    localparam int RT_LO  = 7;
    localparam int RD_HI  = 6;
    localparam int RD_LO  = 4;
    localparam int FN_HI  = 3;
    localparam int FN_LO  = 0;
    localparam int IMM_LO = 0;

    // ctrl vector bit indices: {regwrite, alusrc, regdst, branch, memwrite, memread, memtoreg}
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 0;

    // Field order matches the bit indices above (first field = MSB).
    typedef struct packed {
        logic regwrite;
        logic alusrc;
        logic regdst;
        logic branch;
        logic memwrite;
        logic memread;
        logic memtoreg;
    } ctrl_t;

    // True for opcodes whose rt field names a source register.
    function automatic logic op_reads_rt(input logic [2:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // True for the shift functions that take the rs field as a shift amount.
    function automatic logic fn_is_shift(input logic [3:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL);
    endfunction

endpackage

// File: rtl/id_stage_pipelined_regfile_p.sv
// ----------------------------------------------------------------------------
// regfile_p
// Parametrised register file: two asynchronous read ports, one synchronous
// write port. r0 is hardwired to zero; addresses >= NREG read zero and are
// never written. All registers clear on asynchronous reset.
//
// Macro ID_WB_BYPASS_EN: when defined, a read of the register being written
// in the same cycle returns the write data (write-through).
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   raddr1/rdata1    read port 1
//   raddr2/rdata2    read port 2
//   we/waddr/wdata   write port (rising edge)
// ----------------------------------------------------------------------------
module regfile_p
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);

    localparam logic [REG_ADDR_W:0] NREG_L = (REG_ADDR_W + 1)'(NREG);

    // Storage is sized for the full 3-bit address space; entries at or above
    // NREG are never written and therefore stay at their reset value.
    logic [DATA_W-1:0] regs_q [MAX_REGS];
    logic [DATA_W-1:0] regs_d [MAX_REGS];

    logic wr_en;
    logic rd1_ok;
    logic rd2_ok;

    assign wr_en  = we && (waddr != '0) && ({1'b0, waddr} < NREG_L);
    assign rd1_ok = (raddr1 != '0) && ({1'b0, raddr1} < NREG_L);
    assign rd2_ok = (raddr2 != '0) && ({1'b0, raddr2} < NREG_L);

    always_comb begin
        for (int i = 0; i < MAX_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rd1_ok) begin
            rdata1 = regs_q[raddr1];
`ifdef ID_WB_BYPASS_EN
            if (wr_en && (waddr == raddr1)) begin
                rdata1 = wdata;
            end
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rd2_ok) begin
            rdata2 = regs_q[raddr2];
`ifdef ID_WB_BYPASS_EN
            if (wr_en && (waddr == raddr2)) begin
                rdata2 = wdata;
            end
`endif
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// ----------------------------------------------------------------------------
// id_stage_pipelined
// MIPS16 instruction-decode stage with an ID/EX pipeline register.
// Decodes the IF instruction, reads operands from the register file,
// sign-extends the immediate and registers everything into ID/EX under a
// valid/ready handshake. Load-use hazards against the instruction held in
// ID/EX insert one bubble; flush kills both the held and the incoming
// instruction.
//
// Macro ID_WB_BYPASS_EN: enables same-cycle write-back forwarding into the
// operand read (implemented in regfile_p).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   if_valid/if_ready   IF handshake, inst = instruction word
//   flush               kill held and incoming instruction
//   ex_ready/id_valid   EX handshake for the ID/EX register
//   rd_data1, rd_data2  operands A (rs or shamt) and B (rt)
//   imm_ext             sign-extended immediate
//   dst_reg             destination register (0 when nothing is written)
//   ctrl                {regwrite, alusrc, regdst, branch, memwrite, memread, memtoreg}
//   wb_we/wb_addr/wb_data  write-back port
// ----------------------------------------------------------------------------
module id_stage_pipelined
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int IMM_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [INST_W-1:0]     inst,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  id_valid,
    output logic [DATA_W-1:0]     rd_data1,
    output logic [DATA_W-1:0]     rd_data2,
    output logic [DATA_W-1:0]     imm_ext,
    output logic [REG_ADDR_W-1:0] dst_reg,
    output logic [CTRL_W-1:0]     ctrl,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    function automatic logic [DATA_W-1:0] sign_ext(input logic signed [IMM_W-1:0] v);
        return {{(DATA_W - IMM_W){v[IMM_W-1]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [2:0]             op;
    logic [REG_ADDR_W-1:0]  rs;
    logic [REG_ADDR_W-1:0]  rt;
    logic [REG_ADDR_W-1:0]  rd;
    logic [3:0]             func;
    logic signed [IMM_W-1:0] imm_field;

    assign op        = inst[OP_HI:OP_LO];
    assign rs        = inst[RS_HI:RS_LO];
    assign rt        = inst[RT_HI:RT_LO];
    assign rd        = inst[RD_HI:RD_LO];
    assign func      = inst[FN_HI:FN_LO];
    assign imm_field = inst[IMM_LO + IMM_W - 1:IMM_LO];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    regfile_p #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs),
        .rdata1 (rf_rdata1),
        .raddr2 (rt),
        .rdata2 (rf_rdata2),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t                 dec_ctrl;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic                  dec_shift;
    logic [DATA_W-1:0]     dec_opa;
    logic [DATA_W-1:0]     dec_imm;

    always_comb begin
        dec_ctrl  = '0;
        dec_dst   = '0;
        dec_shift = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.regdst   = 1'b1;
                dec_dst           = rd;
                dec_shift         = fn_is_shift(func);
            end
            OP_ADDI, OP_ORI, OP_SLTI: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_dst           = rt;
            end
            OP_BEQ, OP_BNE: begin
                dec_ctrl.branch = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.memread  = 1'b1;
                dec_ctrl.memtoreg = 1'b1;
                dec_dst           = rt;
            end
            OP_SW: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.memwrite = 1'b1;
            end
            default: begin
                dec_ctrl = '0;
            end
        endcase
    end

    // Shifts carry the shift amount in the rs field, zero-extended.
    assign dec_opa = dec_shift ? DATA_W'(rs) : rf_rdata1;
    assign dec_imm = sign_ext(imm_field);

    // ------------------------------------------------------------------
    // ID/EX register state
    // ------------------------------------------------------------------
    logic                  id_valid_q, id_valid_d;
    logic [DATA_W-1:0]     rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0]     rd_data2_q, rd_data2_d;
    logic [DATA_W-1:0]     imm_ext_q,  imm_ext_d;
    logic [REG_ADDR_W-1:0] dst_reg_q,  dst_reg_d;
    ctrl_t                 ctrl_q,     ctrl_d;

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic hazard;
    logic adv;

    // A load in ID/EX whose destination feeds the incoming instruction
    // cannot be satisfied by the bypass (data arrives after MEM), so stall.
    assign hazard = id_valid_q && ctrl_q.memread && (dst_reg_q != '0) && if_valid &&
                    ((dst_reg_q == rs) || (op_reads_rt(op) && (dst_reg_q == rt)));

    assign adv = ex_ready || !id_valid_q;

    // Held low during reset so the first acceptance happens after release.
    assign if_ready = adv && !hazard && !flush && !reset;

    always_comb begin
        id_valid_d = id_valid_q;
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        imm_ext_d  = imm_ext_q;
        dst_reg_d  = dst_reg_q;
        ctrl_d     = ctrl_q;
        if (flush) begin
            id_valid_d = 1'b0;
            ctrl_d     = '0;
        end else if (adv && hazard) begin
            id_valid_d = 1'b0;
            ctrl_d     = '0;
        end else if (adv) begin
            id_valid_d = if_valid;
            if (if_valid) begin
                rd_data1_d = dec_opa;
                rd_data2_d = rf_rdata2;
                imm_ext_d  = dec_imm;
                dst_reg_d  = dec_dst;
                ctrl_d     = dec_ctrl;
            end else begin
                // Empty slot: keep ctrl inert so nothing downstream fires.
                ctrl_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            imm_ext_q  <= '0;
            dst_reg_q  <= '0;
            ctrl_q     <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            imm_ext_q  <= imm_ext_d;
            dst_reg_q  <= dst_reg_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign id_valid = id_valid_q;
    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign imm_ext  = imm_ext_q;
    assign dst_reg  = dst_reg_q;
    assign ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// ----------------------------------------------------------------------------
// tb_id_stage_pipelined
// Directed bench for id_stage_pipelined. Inputs change on the falling edge;
// registered outputs are checked on the falling edge, if_ready 1 ns after
// the inputs change. Expected ID/EX contents are queued when an instruction
// is expected to be accepted and popped when it is expected to leave.
// ----------------------------------------------------------------------------
module tb_id_stage_pipelined;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_valid;
    logic          if_ready;
    logic [15:0]   inst;
    logic          flush;
    logic          ex_ready;
    logic          id_valid;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic [DW-1:0] imm_ext;
    logic [2:0]    dst_reg;
    logic [6:0]    ctrl;
    logic          wb_we;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;

`ifdef ID_WB_BYPASS_EN
    localparam logic [DW-1:0] BYP_R5 = 16'hBEEF;
`else
    localparam logic [DW-1:0] BYP_R5 = 16'h0000;
`endif

    always #5 clk = ~clk;

    id_stage_pipelined #(.DATA_W(DW), .NREG(8), .IMM_W(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .inst     (inst),
        .flush    (flush),
        .ex_ready (ex_ready),
        .id_valid (id_valid),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .imm_ext  (imm_ext),
        .dst_reg  (dst_reg),
        .ctrl     (ctrl),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    typedef struct packed {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [2:0]    dst;
        logic [6:0]    ctl;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                        input logic [DW-1:0] imm, input logic [2:0] dst, input logic [6:0] ctl);
        exp_t e;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.dst = dst; e.ctl = ctl;
        sb.push_back(e);
    endtask

    // Compare the ID/EX outputs with the oldest queued entry; pop it when the
    // instruction is expected to move on to EX at the next edge.
    task automatic expect_valid(input string tag, input bit do_pop);
        exp_t e;
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb[0];
            if (do_pop) void'(sb.pop_front());
            chk({tag, "_vld"}, 32'(id_valid), 32'd1);
            chk({tag, "_rd1"}, 32'(rd_data1), 32'(e.rd1));
            chk({tag, "_rd2"}, 32'(rd_data2), 32'(e.rd2));
            chk({tag, "_imm"}, 32'(imm_ext),  32'(e.imm));
            chk({tag, "_dst"}, 32'(dst_reg),  32'(e.dst));
            chk({tag, "_ctl"}, 32'(ctrl),     32'(e.ctl));
        end
    endtask

    task automatic expect_bubble(input string tag);
        chk({tag, "_vld"}, 32'(id_valid), 32'd0);
        chk({tag, "_ctl"}, 32'(ctrl),     32'd0);
    endtask

    task automatic expect_all_zero(input string tag);
        chk({tag, "_vld"}, 32'(id_valid), 32'd0);
        chk({tag, "_ctl"}, 32'(ctrl),     32'd0);
        chk({tag, "_rd1"}, 32'(rd_data1), 32'd0);
        chk({tag, "_rd2"}, 32'(rd_data2), 32'd0);
        chk({tag, "_imm"}, 32'(imm_ext),  32'd0);
        chk({tag, "_dst"}, 32'(dst_reg),  32'd0);
        chk({tag, "_rdy"}, 32'(if_ready), 32'd0);
    endtask

    task automatic drive(input logic [15:0] i, input logic v);
        inst     = i;
        if_valid = v;
    endtask

    task automatic chk_rdy(input string tag, input logic want);
        #1;
        chk(tag, 32'(if_ready), 32'(want));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        if_valid = 1'b0;
        inst     = '0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;

        // Reset state
        #2;
        expect_all_zero("reset");

        // Release reset and write r1 = 0x1234
        @(negedge clk);
        reset   = 1'b0;
        wb_we   = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234;
        chk_rdy("rdy_after_reset", 1'b1);

        // add r3,r1,r0
        @(negedge clk);
        wb_we = 1'b0;
        drive(16'h0431, 1'b1);
        chk_rdy("rdy_add", 1'b1);
        push(16'h1234, 16'h0000, 16'h0031, 3'd3, 7'h50);

        // lw r2,5(r1)
        @(negedge clk);
        expect_valid("add_r3", 1'b1);
        drive(16'hC505, 1'b1);
        chk_rdy("rdy_lw", 1'b1);
        push(16'h1234, 16'h0000, 16'h0005, 3'd2, 7'h63);

        // add r4,r2,r1 depends on the load: one stall
        @(negedge clk);
        expect_valid("lw_r2", 1'b1);
        drive(16'h08C1, 1'b1);
        chk_rdy("rdy_hazard", 1'b0);

        @(negedge clk);
        expect_bubble("bubble");
        chk_rdy("rdy_after_bubble", 1'b1);
        push(16'h0000, 16'h1234, 16'hFFC1, 3'd4, 7'h50);

        // addi r5,r0,0x7F
        @(negedge clk);
        expect_valid("add_r4", 1'b1);
        drive(16'h22FF, 1'b1);
        chk_rdy("rdy_addi", 1'b1);
        push(16'h0000, 16'h0000, 16'hFFFF, 3'd5, 7'h60);

        // EX back-pressure for three cycles while ori r6,r1,3 waits
        @(negedge clk);
        expect_valid("addi_hold0", 1'b0);
        ex_ready = 1'b0;
        drive(16'h4703, 1'b1);
        chk_rdy("rdy_stall0", 1'b0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            expect_valid("addi_hold", 1'b0);
            chk_rdy("rdy_stall", 1'b0);
        end
        @(negedge clk);
        expect_valid("addi_hold3", 1'b1);
        ex_ready = 1'b1;
        chk_rdy("rdy_release", 1'b1);
        push(16'h1234, 16'h0000, 16'h0003, 3'd6, 7'h60);

        // flush with a valid sw on the input
        @(negedge clk);
        expect_valid("ori_r6", 1'b1);
        drive(16'hE082, 1'b1);
        flush = 1'b1;
        chk_rdy("rdy_flush", 1'b0);

        @(negedge clk);
        expect_bubble("flushed");
        flush = 1'b0;
        drive(16'h0000, 1'b0);
        chk_rdy("rdy_post_flush", 1'b1);

        // add r6,r5,r5 with write-back of r5 in the same cycle
        @(negedge clk);
        expect_bubble("flushed_gone");
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        drive(16'h16E1, 1'b1);
        chk_rdy("rdy_byp", 1'b1);
        push(BYP_R5, BYP_R5, 16'hFFE1, 3'd6, 7'h50);

        // add r7,r0,r5 with a write to r0 in the same cycle
        @(negedge clk);
        expect_valid("add_r6_byp", 1'b1);
        wb_we = 1'b1; wb_addr = 3'd0; wb_data = 16'hDEAD;
        drive(16'h02F1, 1'b1);
        chk_rdy("rdy_r0w", 1'b1);
        push(16'h0000, 16'hBEEF, 16'hFFF1, 3'd7, 7'h50);

        // sll r1,r2,#3
        @(negedge clk);
        expect_valid("add_r7", 1'b1);
        wb_we = 1'b0;
        drive(16'h0D10, 1'b1);
        chk_rdy("rdy_sll", 1'b1);
        push(16'h0003, 16'h0000, 16'h0010, 3'd1, 7'h50);

        // beq r0,r5: r0 still zero, no destination
        @(negedge clk);
        expect_valid("sll", 1'b1);
        drive(16'h8281, 1'b1);
        chk_rdy("rdy_beq", 1'b1);
        push(16'h0000, 16'hBEEF, 16'h0001, 3'd0, 7'h08);

        // lw r3,0(r0)
        @(negedge clk);
        expect_valid("beq", 1'b1);
        drive(16'hC180, 1'b1);
        chk_rdy("rdy_lw2", 1'b1);
        push(16'h0000, 16'h0000, 16'h0000, 3'd3, 7'h63);

        // add r4,r3,r0 stalls; reset is asserted during the stall
        @(negedge clk);
        expect_valid("lw_r3", 1'b1);
        drive(16'h0C41, 1'b1);
        chk_rdy("rdy_hazard2", 1'b0);
        reset = 1'b1;
        #1;
        expect_all_zero("reset_stall");

        @(negedge clk);
        reset = 1'b0;
        chk_rdy("rdy_after_reset2", 1'b1);
        push(16'h0000, 16'h0000, 16'hFFC1, 3'd4, 7'h50);

        // add r1,r1,r5: register file cleared by reset
        @(negedge clk);
        expect_valid("add_r4_post_reset", 1'b1);
        drive(16'h0691, 1'b1);
        chk_rdy("rdy_add_r1", 1'b1);
        push(16'h0000, 16'h0000, 16'h0011, 3'd1, 7'h50);

        @(negedge clk);
        expect_valid("add_r1_cleared", 1'b1);
        drive(16'h0000, 1'b0);

        @(negedge clk);
        expect_bubble("idle");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised successor of the MIPS16 decode stage. It combines decode, sign-extension and a parametrised register file with an ID/EX pipeline register. The pipeline register uses a valid/ready handshake and supports flush, and the stage detects load-use hazards and stalls on them. It sits between the IF stage (instruction plus valid) and the EX stage (operands, immediate, control plus valid), and takes write-back from the WB stage.

Parameters:
DATA_W, 16, register and operand width (8..32).
NREG, 8, number of architectural registers including r0 (2..8; register-address fields are 3 bits).
IMM_W, 7, immediate field width; sign-extended to DATA_W.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  reset, asynchronous, active-high
if_valid  in  1  inst is valid
if_ready  out  1  stage accepts inst this cycle
inst  in  16  instruction: op[15:13] rs[12:10] rt[9:7] rd[6:4] func[3:0] imm[6:0]
flush  in  1  kill the held and the incoming instruction (branch taken)
ex_ready  in  1  EX accepts the ID/EX register
id_valid  out  1  ID/EX register holds a valid instruction
rd_data1  out  DATA_W  operand A (rs, or zero-extended shamt for sll/srl)
rd_data2  out  DATA_W  operand B (rt)
imm_ext  out  DATA_W  sign-extended imm
dst_reg  out  3  destination register
ctrl  out  7  {regwrite, alusrc, regdst, branch, memwrite, memread, memtoreg}
wb_we  in  1  write-back enable
wb_addr  in  3  write-back register
wb_data  in  DATA_W  write-back data

Behaviour:
- Reset (async): all registers = 0; id_valid = 0; every ID/EX output = 0.
- Register file:
  - Written on the rising edge when wb_we = 1 and wb_addr != 0 and wb_addr < NREG.
  - r0 always reads 0. Addresses >= NREG read 0 and are never written.
- Decode (combinational from inst):
  - op 000 R-type: regwrite = 1, regdst = 1, dst = rd.
  - op 001/010/011 addi/ori/slti: alusrc = 1, regwrite = 1, dst = rt.
  - op 100/101 beq/bne: branch = 1.
  - op 110 lw: alusrc = 1, regwrite = 1, memread = 1, memtoreg = 1, dst = rt.
  - op 111 sw: alusrc = 1, memwrite = 1.
  - For every op that does not write a register, dst = 0.
  - R-type func 000 (sll) or 111 (srl): operand A = {0, rs field}.
- Load-use hazard:
  - hazard = id_valid & ctrl.memread & (dst_reg != 0) & if_valid & (dst_reg == rs, or dst_reg == rt when the op reads rt: R-type, beq, bne, sw).
- Handshake:
  - adv = ex_ready | ~id_valid.
  - if_ready = adv & ~hazard & ~flush.
  - Transfer from IF occurs when if_valid & if_ready.
- ID/EX register update, rising edge, in priority order:
  1. flush → id_valid = 0 and the incoming instruction is dropped.
  2. Else if adv & hazard → bubble: id_valid = 0, ctrl = 0; the IF instruction is held because if_ready = 0.
  3. Else if adv → capture the decoded inst; id_valid = if_valid.
  4. Else (~adv) → hold all outputs unchanged.
- When id_valid = 0, ctrl is 0: bubbles never write memory or registers.
- Latency: 1 cycle from accepted inst to id_valid. Throughput is 1 per cycle with no hazard.
- Operands are read in the capture cycle; the write-back bypass is defined under Optional Feature.
- Reset mid-stall: the stage clears immediately, and if_ready rises the first cycle after reset is deasserted.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: when wb_we & (wb_addr != 0) & (wb_addr == rs or rt), the captured operand takes wb_data in the same cycle (write-through).
- Undefined: the operand takes the old register value; software needs one extra separating instruction.

Decomposition:
- Package mips16_pkg holds:
  - opcode and func constants (OP_RTYPE .. OP_SW, FN_SLL .. FN_SRL);
  - field bit positions;
  - the ctrl bit indices;
  - a ctrl_t packed struct.
- Sub-module regfile_p (parameters DATA_W, NREG): 2 async read ports, 1 sync write port, r0 hardwired to 0, bypass under the macro.

Test Plan:
- Reset then write r1 = 0x1234 via WB; decode add r3,r1,r0 → rd_data1 = 0x1234, rd_data2 = 0, ctrl = 1010000, dst_reg = 3, id_valid = 1 one cycle later.
- lw r2,5(r1) followed by add r4,r2,r1 → if_ready = 0 for 1 cycle, one bubble (id_valid = 0, ctrl = 0), then add issued; imm_ext = 0x0005. Decode of addi with imm 7'h7F → imm_ext = 0xFFFF.
- ex_ready = 0 for 3 cycles with a valid instruction held → outputs stable, if_ready = 0; the next instruction is accepted the cycle ex_ready = 1.
- flush asserted with if_valid = 1 → id_valid = 0 next cycle, and the instruction is not presented afterwards.
- wb_we = 1, wb_addr = 5, wb_data = 0xBEEF in the same cycle as add r6,r5,r5 → operands = 0xBEEF with ID_WB_BYPASS_EN defined, previous value without it. wb_addr = 0 write leaves r0 reading 0.
- sll r1,r2,#3 (rs field = 3) → rd_data1 = 0x0003. Assert reset during a hazard stall → all outputs 0 immediately.
